twos_to_signmag: RTL

TWOS_TO_SIGNMAG -- requirements
Module: twos_to_signmag

---
 rtl/twos_to_signmag.sv | 118 +++++++++++
 1 files changed

// File: rtl/twos_to_signmag.sv
// ============================================================================
//  Module   : twos_to_signmag
//  Purpose  : Two's-complement to sign/magnitude converter. Negative operands
//             are negated by a bit-serial unit, LSB first, one bit per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twos_to_signmag #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             SIGN,
    output logic [WIDTH-1:0] MAGNITUDE,
    output logic             OVERFLOW
);

    localparam int                 CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   C_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               seen_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               sign_q;
    logic [WIDTH-1:0]   mag_q;
    logic               ovf_q;

    // Serial negation: copy bits up to and including the first 1, invert the rest.
    always_comb begin
        res_d = {(seen_q ? ~shreg_q[0] : shreg_q[0]), res_q[WIDTH-1:1]};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        shreg_q    <= DATA_IN;
                        res_q      <= '0;
                        cnt_q      <= '0;
                        seen_q     <= 1'b0;
                        sign_q     <= DATA_IN[WIDTH-1];
                        ovf_q      <= (DATA_IN == C_MOST_NEG);
                        in_ready_q <= 1'b0;
                        if (DATA_IN[WIDTH-1]) begin
                            state_q <= SHIFT;
                        end else begin
                            mag_q       <= DATA_IN;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_q >> 1;
                    seen_q  <= seen_q | shreg_q[0];
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == C_LAST) begin
                        mag_q       <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign SIGN      = sign_q;
    assign MAGNITUDE = mag_q;
    assign OVERFLOW  = ovf_q;

endmodule

`default_nettype wire
